// File: rtl/out_sig_pkg.sv
// Shared definitions for the output-signature MISR: default signature
// parameters, the run-state encoding and the fold chunk-count helper.
package out_sig_pkg;

  localparam int          SIG_W = 32;
  localparam logic [31:0] POLY  = 32'h04C11DB7;
  localparam logic [31:0] SEED  = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Number of sig_w-wide chunks needed to cover an in_w-bit sample.
  function automatic int fold_width(input int in_w, input int sig_w = SIG_W);
    return (in_w + sig_w - 1) / sig_w;
  endfunction

endpackage

// File: rtl/misr_fold.sv
// Combinational MISR step: XOR-folds a zero-padded sample into one
// signature-wide word and merges it into the shifted signature.
module misr_fold #(
  parameter int               IN_W  = 161,
  parameter int               SIG_W = out_sig_pkg::SIG_W,
  parameter logic [SIG_W-1:0] POLY  = out_sig_pkg::POLY
) (
  input  logic [IN_W-1:0]  sample_data_i,
  input  logic [SIG_W-1:0] sig_i,
  output logic [SIG_W-1:0] sig_next_o
);
  import out_sig_pkg::*;

  localparam int N_CHUNK = fold_width(IN_W, SIG_W);
  localparam int PAD_W   = N_CHUNK * SIG_W;

  logic [PAD_W-1:0] padded;
  logic [SIG_W-1:0] fold;

  // Fold all chunks of the padded sample, then apply one LFSR shift plus feedback.
  always_comb begin
    // NOTE: every output of this block is given a default first so no path leaves it unassigned (no latch).
    padded             = '0;
    padded[IN_W-1:0]   = sample_data_i;
    fold               = '0;
    for (int c = 0; c < N_CHUNK; c++) begin
      fold = fold ^ padded[c*SIG_W +: SIG_W];
    end
    sig_next_o = {sig_i[SIG_W-2:0], 1'b0}
               ^ (sig_i[SIG_W-1] ? POLY : '0)
               ^ fold;
  end

endmodule

// File: rtl/out_signature_misr.sv
// Output-signature compactor: folds a programmed number of DUT output samples
// into a MISR and offers the final signature over a valid/ready handshake.
// Optional golden-signature comparator enabled by OUT_SIGNATURE_MISR_GOLDEN_EN.
module out_signature_misr #(
  parameter int               IN_W  = 161,
  parameter int               SIG_W = out_sig_pkg::SIG_W,
  parameter logic [SIG_W-1:0] POLY  = out_sig_pkg::POLY,
  parameter logic [SIG_W-1:0] SEED  = out_sig_pkg::SEED,
  parameter int               CNT_W = 16
) (
  input  logic             clock_0,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] sample_count,
  input  logic             sample_valid,
  input  logic [IN_W-1:0]  sample_data,
  output logic             busy,
  output logic             sig_valid,
  input  logic             sig_ready,
  output logic [SIG_W-1:0] signature,
`ifdef OUT_SIGNATURE_MISR_GOLDEN_EN
  input  logic [SIG_W-1:0] golden,
  output logic             mismatch,
`endif
  output logic [CNT_W-1:0] accepted
);
  import out_sig_pkg::*;

  state_e           state_q, state_d;
  logic [SIG_W-1:0] sig_q, sig_d, sig_step;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             busy_q, sig_valid_q;
  logic             load;

  misr_fold #(
    .IN_W  (IN_W),
    .SIG_W (SIG_W),
    .POLY  (POLY)
  ) u_fold (
    .sample_data_i (sample_data),
    .sig_i         (sig_q),
    .sig_next_o    (sig_step)
  );

  // Next-state logic: run control, sample folding, counters and restart.
  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) load = 1'b1;
      end
      RUN: begin
        if (sample_valid) begin
          sig_d = sig_step;
          rem_d = rem_q - 1'b1;
          if (acc_q != '1) acc_d = acc_q + 1'b1;
          if (rem_q == CNT_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        // A start here either restarts after a completed handshake or
        // discards an unread signature; both reload the run.
        if (start)          load    = 1'b1;
        else if (sig_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      sig_d   = SEED;
      rem_d   = sample_count;
      acc_d   = '0;
      state_d = (sample_count == '0) ? DONE : RUN;
    end
  end

  // State and output registers; outputs are decoded from the next state so they are flops.
  always_ff @(posedge clock_0 or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q     <= IDLE;
      sig_q       <= '0;
      rem_q       <= '0;
      acc_q       <= '0;
      busy_q      <= 1'b0;
      sig_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sig_q       <= sig_d;
      rem_q       <= rem_d;
      acc_q       <= acc_d;
      busy_q      <= (state_d == RUN);
      sig_valid_q <= (state_d == DONE);
    end
  end

`ifdef OUT_SIGNATURE_MISR_GOLDEN_EN
  logic mismatch_q;
  logic done_entry;

  assign done_entry = (state_d == DONE) && ((state_q != DONE) || load);

  // Compare against golden when DONE is entered; hold in DONE, clear on leaving.
  always_ff @(posedge clock_0 or posedge reset) begin
    if (reset)               mismatch_q <= 1'b0;
    else if (done_entry)     mismatch_q <= (sig_d != golden);
    else if (state_d != DONE) mismatch_q <= 1'b0;
  end

  assign mismatch = mismatch_q;
`endif

  assign busy      = busy_q;
  assign sig_valid = sig_valid_q;
  assign signature = sig_q;
  assign accepted  = acc_q;

endmodule

// File: tb/tb_out_signature_misr.sv
// Randomized scoreboard bench for out_signature_misr with a bit-level reference model.
module tb_out_signature_misr;

  localparam int          IN_W  = 161;
  localparam int          SIG_W = 32;
  localparam int          CNT_W = 16;
  localparam logic [31:0] POLY  = 32'h04C11DB7;
  localparam logic [31:0] SEED  = 32'hFFFFFFFF;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, start0;
  logic [CNT_W-1:0] sample_count;
  logic             sample_valid;
  logic [IN_W-1:0]  sample_data;
  logic             sig_ready, sig_ready0;
  logic             busy, sig_valid, busy0, sig_valid0;
  logic [SIG_W-1:0] signature, signature0;
  logic [CNT_W-1:0] accepted, accepted0;
`ifdef OUT_SIGNATURE_MISR_GOLDEN_EN
  logic [SIG_W-1:0] golden, golden0;
  logic             mismatch, mismatch0;
`endif

  always #5 clk = ~clk;

  out_signature_misr dut (
    .clock_0      (clk),
    .reset        (rst),
    .start        (start),
    .sample_count (sample_count),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .busy         (busy),
    .sig_valid    (sig_valid),
    .sig_ready    (sig_ready),
    .signature    (signature),
`ifdef OUT_SIGNATURE_MISR_GOLDEN_EN
    .golden       (golden),
    .mismatch     (mismatch),
`endif
    .accepted     (accepted)
  );

  out_signature_misr #(.SEED(32'h0)) dut0 (
    .clock_0      (clk),
    .reset        (rst),
    .start        (start0),
    .sample_count (sample_count),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .busy         (busy0),
    .sig_valid    (sig_valid0),
    .sig_ready    (sig_ready0),
    .signature    (signature0),
`ifdef OUT_SIGNATURE_MISR_GOLDEN_EN
    .golden       (golden0),
    .mismatch     (mismatch0),
`endif
    .accepted     (accepted0)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0]      sig;
    logic [CNT_W-1:0] acc;
    logic             mis;
  } exp_t;

  exp_t            exp_q[$];
  logic [IN_W-1:0] stim_q[$];

  // Reference: bit b of a sample lands on signature bit (b mod 32); then one
  // polynomial shift step per sample.
  function automatic logic [31:0] ref_sig(input logic [31:0] seed, input int n);
    logic [31:0]     s;
    logic [31:0]     f;
    logic [IN_W-1:0] d;
    s = seed;
    for (int k = 0; k < n; k++) begin
      d = stim_q[k];
      f = '0;
      for (int b = 0; b < IN_W; b++) f[b % 32] = f[b % 32] ^ d[b];
      s = (s << 1) ^ (s[31] ? POLY : 32'h0) ^ f;
    end
    return s;
  endfunction

  function automatic logic [IN_W-1:0] rnd_sample();
    logic [191:0] w;
    for (int k = 0; k < 6; k++) w[k*32 +: 32] = $urandom;
    return w[IN_W-1:0];
  endfunction

  // Monitor: each new presentation of sig_valid consumes one expectation.
  logic sv_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sv_prev <= 1'b0;
    end else begin
      if (sig_valid && !sv_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sig_valid actual=1 expected=0");
        end else begin
          e = exp_q.pop_front();
          check("sb_signature", 64'(signature), 64'(e.sig));
          check("sb_accepted", 64'(accepted), 64'(e.acc));
`ifdef OUT_SIGNATURE_MISR_GOLDEN_EN
          check("sb_mismatch", 64'(mismatch), 64'(e.mis));
`endif
        end
      end
      sv_prev <= sig_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int n);
    stim_q.delete();
    for (int i = 0; i < n; i++) stim_q.push_back(rnd_sample());
  endtask

  task automatic issue(input int n);
    exp_t e;
    e.sig = ref_sig(SEED, n);
    e.acc = CNT_W'(n);
`ifdef OUT_SIGNATURE_MISR_GOLDEN_EN
    e.mis = (e.sig != golden);
`else
    e.mis = 1'b0;
`endif
    exp_q.push_back(e);
    start        = 1'b1;
    sample_count = CNT_W'(n);
    step();
    start        = 1'b0;
  endtask

  task automatic feed(input int n, input int gap_pct);
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        sample_valid = 1'b0;
        sample_data  = rnd_sample();
        step();
      end
      sample_valid = 1'b1;
      sample_data  = stim_q[i];
      step();
    end
    sample_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!sig_valid && k < 64) begin
      step();
      k++;
    end
    check(name, 64'(sig_valid), 64'd1);
  endtask

  task automatic handshake(input int delay);
    repeat (delay) step();
    sig_ready = 1'b1;
    step();
    sig_ready = 1'b0;
    check("sig_valid_clear", 64'(sig_valid), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst          = 1'b1;
    start        = 1'b0;
    start0       = 1'b0;
    sample_count = '0;
    sample_valid = 1'b0;
    sample_data  = '0;
    sig_ready    = 1'b0;
    sig_ready0   = 1'b0;
`ifdef OUT_SIGNATURE_MISR_GOLDEN_EN
    golden       = 32'h0;
    golden0      = 32'h0;
`endif
    step();
    step();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sig_valid", 64'(sig_valid), 64'd0);
    check("rst_signature", 64'(signature), 64'd0);
    check("rst_accepted", 64'(accepted), 64'd0);
`ifdef OUT_SIGNATURE_MISR_GOLDEN_EN
    check("rst_mismatch", 64'(mismatch), 64'd0);
`endif
    rst = 1'b0;
    step();

    // Zero-length run: DONE the cycle after start with the seed.
    fill(0);
    issue(0);
    check("zero_sig_valid", 64'(sig_valid), 64'd1);
    check("zero_busy", 64'(busy), 64'd0);
    check("zero_signature", 64'(signature), 64'hFFFFFFFF);
    check("zero_accepted", 64'(accepted), 64'd0);
    handshake(0);

    // Single all-zero sample from the default seed.
    stim_q.delete();
    stim_q.push_back('0);
`ifdef OUT_SIGNATURE_MISR_GOLDEN_EN
    golden = 32'hFB3EE249;
`endif
    issue(1);
    check("one_busy", 64'(busy), 64'd1);
    feed(1, 0);
    check("one_latency", 64'(sig_valid), 64'd1);
    check("one_signature", 64'(signature), 64'hFB3EE249);
`ifdef OUT_SIGNATURE_MISR_GOLDEN_EN
    check("golden_match", 64'(mismatch), 64'd0);
`endif
    handshake(2);
`ifdef OUT_SIGNATURE_MISR_GOLDEN_EN
    golden = 32'h0;
    issue(1);
    feed(1, 0);
    check("golden_diff_valid", 64'(sig_valid), 64'd1);
    check("golden_diff", 64'(mismatch), 64'd1);
    handshake(0);
    check("golden_clear", 64'(mismatch), 64'd0);
`endif

    // Gapped stream 1,0,1,0,1,1 with an ignored start in RUN.
    fill(4);
    issue(4);
    sample_valid = 1'b1; sample_data = stim_q[0]; step();
    sample_valid = 1'b0; start = 1'b1; sample_count = 16'd9; step();
    start = 1'b0;
    sample_valid = 1'b1; sample_data = stim_q[1]; step();
    check("gap_accepted_mid", 64'(accepted), 64'd2);
    sample_valid = 1'b0; step();
    sample_valid = 1'b1; sample_data = stim_q[2]; step();
    check("gap_not_done", 64'(sig_valid), 64'd0);
    check("gap_busy", 64'(busy), 64'd1);
    sample_data = stim_q[3]; step();
    sample_valid = 1'b0;
    check("gap_done", 64'(sig_valid), 64'd1);
    check("gap_accepted", 64'(accepted), 64'd4);
    step();
    check("gap_hold1", 64'(sig_valid), 64'd1);
    step();
    check("gap_hold2", 64'(sig_valid), 64'd1);
    handshake(0);

    // Restart from DONE without reading (discard), then with ready in the same cycle.
    fill(3);
    issue(3);
    feed(3, 0);
    wait_valid("discard_first_valid");
    fill(2);
    issue(2);
    check("discard_restart_busy", 64'(busy), 64'd1);
    feed(2, 30);
    wait_valid("discard_second_valid");
    fill(3);
    sig_ready = 1'b1;
    issue(3);
    sig_ready = 1'b0;
    check("ready_restart_busy", 64'(busy), 64'd1);
    feed(3, 20);
    wait_valid("ready_restart_valid");
    handshake(1);

    // Reset mid-run, then rerun the same stream.
    fill(5);
    issue(5);
    feed(2, 0);
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_sig_valid", 64'(sig_valid), 64'd0);
    check("midrst_signature", 64'(signature), 64'd0);
    check("midrst_accepted", 64'(accepted), 64'd0);
    exp_q.delete();
    step();
    rst = 1'b0;
    step();
    issue(5);
    feed(5, 0);
    wait_valid("rerun_valid");
    handshake(0);

    // Zero seed: only bit 160 set yields signature 1, one cycle after the sample.
    start0 = 1'b1;
    sample_count = 16'd1;
    step();
    start0 = 1'b0;
    check("seed0_busy", 64'(busy0), 64'd1);
    sample_valid = 1'b1;
    sample_data  = '0;
    sample_data[160] = 1'b1;
    step();
    sample_valid = 1'b0;
    check("seed0_valid", 64'(sig_valid0), 64'd1);
    check("seed0_signature", 64'(signature0), 64'd1);
    sig_ready0 = 1'b1;
    step();
    sig_ready0 = 1'b0;
    check("seed0_clear", 64'(sig_valid0), 64'd0);

    // Random runs.
    for (int r = 0; r < 25; r++) begin
      n = ($urandom_range(7) == 0) ? 0 : $urandom_range(1, 10);
      fill(n);
`ifdef OUT_SIGNATURE_MISR_GOLDEN_EN
      golden = $urandom_range(1) ? ref_sig(SEED, n) : $urandom;
`endif
      issue(n);
      feed(n, 30);
      wait_valid("rand_valid");
      handshake($urandom_range(0, 3));
    end

    step();
    step();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
